// File: rtl/input_port_pkg.sv
// Shared constants, register kinds and the address decoder for the input port bank.
package input_port_pkg;

  localparam int MAX_PORT_COUNT = 4;
  localparam int MAX_PORT_WIDTH = 4;

  localparam logic [11:0] DEF_DATA_BASE   = 12'hF40;
  localparam logic [11:0] DEF_MASK_BASE   = 12'hF14;
  localparam logic [11:0] DEF_FACTOR_BASE = 12'hF04;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_DATA,
    REG_RELATION,
    REG_MASK,
    REG_FACTOR
  } reg_kind_e;

  typedef struct packed {
    reg_kind_e   kind;
    logic [1:0]  port;
  } reg_sel_t;

  // Relation addresses of ports without a relation register decode as unmatched.
  function automatic reg_sel_t decode_addr(
    input logic [11:0]               addr,
    input int                        port_count,
    input logic [MAX_PORT_COUNT-1:0] rel_ports,
    input logic [11:0]               data_base,
    input logic [11:0]               mask_base,
    input logic [11:0]               factor_base
  );
    reg_sel_t sel;
    sel.kind = REG_NONE;
    sel.port = '0;
    for (int n = 0; n < MAX_PORT_COUNT; n++) begin
      if (n < port_count) begin
        if (addr == data_base + 12'(2 * n)) begin
          sel.kind = REG_DATA;
          sel.port = 2'(n);
        end
        if (rel_ports[n] && (addr == data_base + 12'(2 * n + 1))) begin
          sel.kind = REG_RELATION;
          sel.port = 2'(n);
        end
        if (addr == mask_base + 12'(n)) begin
          sel.kind = REG_MASK;
          sel.port = 2'(n);
        end
        if (addr == factor_base + 12'(n)) begin
          sel.kind = REG_FACTOR;
          sel.port = 2'(n);
        end
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/input_port_bank_if.sv
// Peripheral bus seen by the input port bank: CPU side is master, the bank is slave.
interface input_port_bank_if;
  logic [11:0] bus_addr;
  logic        bus_write_en;
  logic        bus_read_en;
  logic [3:0]  bus_data_in;
  logic [3:0]  bus_data_out;
  logic        bus_hit;

  modport master (
    output bus_addr, bus_write_en, bus_read_en, bus_data_in,
    input  bus_data_out, bus_hit
  );

  modport slave (
    input  bus_addr, bus_write_en, bus_read_en, bus_data_in,
    output bus_data_out, bus_hit
  );
endinterface

// File: rtl/input_debounce.sv
// One input port: two-flop synchroniser, shared debounce counter, filtered value and edge triggers.
module input_debounce #(
  parameter int WIDTH          = 4,
  parameter int DEBOUNCE_TICKS = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic [WIDTH-1:0] i_pin,
  input  logic [WIDTH-1:0] i_relation,
  output logic [WIDTH-1:0] o_filtered,
  output logic [WIDTH-1:0] o_trigger
);

  logic [WIDTH-1:0] r_sync_p0;
  logic [WIDTH-1:0] r_sync_p1;
  logic [WIDTH-1:0] r_filt_p2;
  logic [7:0]       r_cnt;
  logic             w_differ;
  logic             w_accept;

  assign w_differ   = (r_sync_p1 != r_filt_p2);
  assign w_accept   = clk_en && w_differ && (r_cnt == 8'(DEBOUNCE_TICKS));
  // A bit fires when it changes and its old level matches the relation level.
  assign o_trigger  = w_accept ? ((r_sync_p1 ^ r_filt_p2) & ~(r_filt_p2 ^ i_relation)) : '0;
  assign o_filtered = r_filt_p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync_p0 <= '1;
      r_sync_p1 <= '1;
      r_filt_p2 <= '1;
      r_cnt     <= '0;
    end else if (clk_en) begin
      r_sync_p0 <= i_pin;
      // sync p0 -> p1
      r_sync_p1 <= r_sync_p0;
      // p1 -> filtered once stable long enough
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (r_cnt == 8'(DEBOUNCE_TICKS)) begin
        r_filt_p2 <= r_sync_p1;
        r_cnt     <= '0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/input_port_bank.sv
// Bank of debounced input ports with relation/mask registers and clear-on-read interrupt factors.
module input_port_bank
  import input_port_pkg::*;
#(
  parameter int                        PORT_COUNT     = 2,
  parameter int                        PORT_WIDTH     = 4,
  parameter logic [MAX_PORT_COUNT-1:0] RELATION_PORTS = 4'b0001,
  parameter int                        DEBOUNCE_TICKS = 0,
  parameter logic [11:0]               DATA_BASE      = DEF_DATA_BASE,
  parameter logic [11:0]               MASK_BASE      = DEF_MASK_BASE,
  parameter logic [11:0]               FACTOR_BASE    = DEF_FACTOR_BASE
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clk_en,
  input  logic [PORT_COUNT*PORT_WIDTH-1:0] port_in,
  input_port_bank_if.slave                 bus,
  output logic [PORT_COUNT-1:0]            factor,
  output logic                             interrupt_req
);

  logic [PORT_WIDTH-1:0] r_rel  [PORT_COUNT];
  logic [PORT_WIDTH-1:0] r_mask [PORT_COUNT];
  logic [PORT_COUNT-1:0] r_factor;
  logic [PORT_WIDTH-1:0] w_filt [PORT_COUNT];
  logic [PORT_COUNT-1:0] w_fire;
  reg_sel_t              w_sel;
  logic [3:0]            w_rd;

  assign w_sel = decode_addr(bus.bus_addr, PORT_COUNT, RELATION_PORTS,
                             DATA_BASE, MASK_BASE, FACTOR_BASE);

  for (genvar g = 0; g < PORT_COUNT; g++) begin : g_port
    logic [PORT_WIDTH-1:0] w_rel_eff;
    logic [PORT_WIDTH-1:0] w_trig;

    // Ports without a relation register behave as falling-edge only.
    assign w_rel_eff = RELATION_PORTS[g] ? r_rel[g] : '1;

    input_debounce #(
      .WIDTH          (PORT_WIDTH),
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
    ) u_deb (
      .clk        (clk),
      .reset      (reset),
      .clk_en     (clk_en),
      .i_pin      (port_in[g*PORT_WIDTH +: PORT_WIDTH]),
      .i_relation (w_rel_eff),
      .o_filtered (w_filt[g]),
      .o_trigger  (w_trig)
    );

    assign w_fire[g] = |(r_mask[g] & w_trig);
  end

  always_comb begin
    w_rd = '0;
    for (int n = 0; n < PORT_COUNT; n++) begin
      if (w_sel.port == 2'(n)) begin
        case (w_sel.kind)
          REG_DATA:     w_rd[PORT_WIDTH-1:0] = w_filt[n];
          REG_RELATION: w_rd[PORT_WIDTH-1:0] = r_rel[n];
          REG_MASK:     w_rd[PORT_WIDTH-1:0] = r_mask[n];
          REG_FACTOR:   w_rd[0]              = r_factor[n];
          default:      ;
        endcase
      end
    end
  end

  assign bus.bus_data_out = w_rd;
  assign bus.bus_hit      = (w_sel.kind != REG_NONE);
  assign factor           = r_factor;
  assign interrupt_req    = |r_factor;

  // A new edge takes priority over a clearing read of the same flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_factor <= '0;
      for (int n = 0; n < PORT_COUNT; n++) begin
        r_rel[n]  <= '0;
        r_mask[n] <= '0;
      end
    end else if (clk_en) begin
      for (int n = 0; n < PORT_COUNT; n++) begin
        if (w_fire[n]) begin
          r_factor[n] <= 1'b1;
        end else if (bus.bus_read_en && (w_sel.kind == REG_FACTOR) && (w_sel.port == 2'(n))) begin
          r_factor[n] <= 1'b0;
        end
        if (bus.bus_write_en && (w_sel.port == 2'(n))) begin
          if (w_sel.kind == REG_RELATION) r_rel[n]  <= bus.bus_data_in[PORT_WIDTH-1:0];
          if (w_sel.kind == REG_MASK)     r_mask[n] <= bus.bus_data_in[PORT_WIDTH-1:0];
        end
      end
    end
  end

endmodule
